// File: rtl/sdr_cmd_decode.sv
// sdr_cmd_decode: host-command front end of the SDRAM controller.
// Decodes the 3-bit host command into one-cycle strobes for the sequencer and
// the acknowledge stage, holds the timing-config and refresh-interval
// registers, and runs the refresh-interval counter that raises ref_req.
`timescale 1ns/1ps

module sdr_cmd_decode #(
    parameter int                 ASIZE     = 23,
    parameter int                 RFCNT_W   = 16,
    parameter logic [RFCNT_W-1:0] RFCNT_DEF = RFCNT_W'(1560)
) (
    input  logic             clk0,
    input  logic             reset,
    input  logic [2:0]       cmd,
    input  logic [ASIZE-1:0] addr,
    input  logic             cmdack,
    input  logic             seq_busy,
    output logic             cmack,
    output logic             load_time,
    output logic             load_rfcnt,
    output logic             do_reada,
    output logic             do_writea,
    output logic             do_refresh,
    output logic             do_precharge,
    output logic             do_load_mode,
    output logic             ref_req,
    output logic [1:0]       sc_cl,
    output logic [1:0]       sc_rc,
    output logic [3:0]       sc_rrd,
    output logic             sc_pm,
    output logic [3:0]       sc_bl
);

    typedef enum logic [2:0] {
        CMD_NOP        = 3'd0,
        CMD_READA      = 3'd1,
        CMD_WRITEA     = 3'd2,
        CMD_REFRESH    = 3'd3,
        CMD_PRECHARGE  = 3'd4,
        CMD_LOAD_MODE  = 3'd5,
        CMD_LOAD_TIME  = 3'd6,
        CMD_LOAD_RFCNT = 3'd7
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_RELEASE
    } state_t;

    // All one-cycle output strobes, registered together.
    typedef struct packed {
        logic cmack;
        logic load_time;
        logic load_rfcnt;
        logic reada;
        logic writea;
        logic refresh;
        logic precharge;
        logic load_mode;
    } pulse_t;

    // An interval of 0 would stall the counter at expiry; treat it as 1.
    function automatic logic [RFCNT_W-1:0] sat1(input logic [RFCNT_W-1:0] v);
        return (v == '0) ? RFCNT_W'(1) : v;
    endfunction

    state_t             state_q,   state_d;
    cmd_t               cmd_in_q,  cmd_in_d;   // registered host command
    cmd_t               op_q,      op_d;       // command being executed
    logic               auto_q,    auto_d;     // handshake started by auto refresh
    pulse_t             pulse_q,   pulse_d;
    logic               ref_req_q, ref_req_d;
    logic [RFCNT_W-1:0] rfcnt_q,   rfcnt_d;
    logic [RFCNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]         sc_cl_q,   sc_cl_d;
    logic [1:0]         sc_rc_q,   sc_rc_d;
    logic [3:0]         sc_rrd_q,  sc_rrd_d;
    logic               sc_pm_q,   sc_pm_d;
    logic [3:0]         sc_bl_q,   sc_bl_d;
    logic               expire;

    // Address bits above the refresh-interval field carry no configuration.
    generate
        if (ASIZE > RFCNT_W) begin : g_unused_addr
            logic unused_addr;
            assign unused_addr = ^addr[ASIZE-1:RFCNT_W];
        end
    endgenerate

    // Command FSM: pick the next state and the strobe to issue next cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        auto_d   = auto_q;
        pulse_d  = '0;
        cmd_in_d = cmd_t'(cmd);

        case (state_q)
            S_IDLE: begin
                if (ref_req_q && !seq_busy) begin
                    // Refresh wins over the host; its command stays pending.
                    pulse_d.refresh = 1'b1;
                    pulse_d.cmack   = 1'b1;
                    auto_d          = 1'b1;
                    state_d         = S_WAIT_ACK;
                end else if (cmd_in_q != CMD_NOP) begin
                    op_d    = cmd_in_q;
                    auto_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                case (op_q)
                    CMD_LOAD_TIME: begin
                        pulse_d.load_time = 1'b1;
                        state_d           = S_WAIT_ACK;
                    end
                    CMD_LOAD_RFCNT: begin
                        pulse_d.load_rfcnt = 1'b1;
                        state_d            = S_WAIT_ACK;
                    end
                    default: begin
                        if (!seq_busy) begin
                            pulse_d.cmack     = 1'b1;
                            pulse_d.reada     = (op_q == CMD_READA);
                            pulse_d.writea    = (op_q == CMD_WRITEA);
                            pulse_d.refresh   = (op_q == CMD_REFRESH);
                            pulse_d.precharge = (op_q == CMD_PRECHARGE);
                            pulse_d.load_mode = (op_q == CMD_LOAD_MODE);
                            state_d           = S_WAIT_ACK;
                        end
                    end
                endcase
            end
            S_WAIT_ACK: begin
                if (cmdack) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // A host command must be withdrawn before another is accepted,
                // so nothing is issued twice; an auto refresh owes no withdrawal.
                if (auto_q || cmd_in_q == CMD_NOP) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Refresh counter, interval register and timing configuration.
    always_comb begin
        expire    = (cnt_q == '0);
        rfcnt_d   = rfcnt_q;
        cnt_d     = cnt_q - RFCNT_W'(1);
        ref_req_d = ref_req_q;
        sc_cl_d   = sc_cl_q;
        sc_rc_d   = sc_rc_q;
        sc_rrd_d  = sc_rrd_q;
        sc_pm_d   = sc_pm_q;
        sc_bl_d   = sc_bl_q;

        if (pulse_d.load_rfcnt) begin
            rfcnt_d = addr[RFCNT_W-1:0];
            cnt_d   = sat1(addr[RFCNT_W-1:0]);
        end else if (expire) begin
            cnt_d   = sat1(rfcnt_q);
        end

        // A new expiry outranks the clear from a refresh issued in the same cycle.
        if (expire)               ref_req_d = 1'b1;
        else if (pulse_d.refresh) ref_req_d = 1'b0;

        if (pulse_d.load_time) begin
            sc_cl_d  = addr[1:0];
            sc_rc_d  = addr[3:2];
            sc_rrd_d = addr[7:4];
            sc_pm_d  = addr[8];
            sc_bl_d  = addr[12:9];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk0) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            state_q   <= S_IDLE;
            cmd_in_q  <= CMD_NOP;
            op_q      <= CMD_NOP;
            auto_q    <= 1'b0;
            pulse_q   <= '0;
            ref_req_q <= 1'b0;
            rfcnt_q   <= RFCNT_DEF;
            cnt_q     <= RFCNT_DEF;
            sc_cl_q   <= 2'd3;
            sc_rc_q   <= 2'd3;
            sc_rrd_q  <= 4'd8;
            sc_pm_q   <= 1'b0;
            sc_bl_q   <= 4'd8;
        end else begin
            state_q   <= state_d;
            cmd_in_q  <= cmd_in_d;
            op_q      <= op_d;
            auto_q    <= auto_d;
            pulse_q   <= pulse_d;
            ref_req_q <= ref_req_d;
            rfcnt_q   <= rfcnt_d;
            cnt_q     <= cnt_d;
            sc_cl_q   <= sc_cl_d;
            sc_rc_q   <= sc_rc_d;
            sc_rrd_q  <= sc_rrd_d;
            sc_pm_q   <= sc_pm_d;
            sc_bl_q   <= sc_bl_d;
        end
    end

    assign cmack        = pulse_q.cmack;
    assign load_time    = pulse_q.load_time;
    assign load_rfcnt   = pulse_q.load_rfcnt;
    assign do_reada     = pulse_q.reada;
    assign do_writea    = pulse_q.writea;
    assign do_refresh   = pulse_q.refresh;
    assign do_precharge = pulse_q.precharge;
    assign do_load_mode = pulse_q.load_mode;
    assign ref_req      = ref_req_q;
    assign sc_cl        = sc_cl_q;
    assign sc_rc        = sc_rc_q;
    assign sc_rrd       = sc_rrd_q;
    assign sc_pm        = sc_pm_q;
    assign sc_bl        = sc_bl_q;

endmodule

// File: tb/tb_sdr_cmd_decode.sv
// tb_sdr_cmd_decode: directed stimulus for sdr_cmd_decode. Each command pushes
// its expected strobe vector into a queue; a monitor compares every strobe the
// DUT presents against the head of that queue.
`timescale 1ns/1ps

module tb_sdr_cmd_decode;

    // Strobe vector order: {cmack, load_time, load_rfcnt, reada, writea, refresh, precharge, load_mode}
    localparam logic [7:0] P_READA   = 8'b1001_0000;
    localparam logic [7:0] P_WRITEA  = 8'b1000_1000;
    localparam logic [7:0] P_REFRESH = 8'b1000_0100;
    localparam logic [7:0] P_PRECH   = 8'b1000_0010;
    localparam logic [7:0] P_LTIME   = 8'b0100_0000;
    localparam logic [7:0] P_LRF     = 8'b0010_0000;
    localparam logic [12:0] CFG_DEF  = {2'd3, 2'd3, 4'd8, 1'b0, 4'd8};

    logic        clk0, reset, cmdack, seq_busy;
    logic [2:0]  cmd;
    logic [22:0] addr;
    logic        cmack, load_time, load_rfcnt;
    logic        do_reada, do_writea, do_refresh, do_precharge, do_load_mode;
    logic        ref_req, sc_pm;
    logic [1:0]  sc_cl, sc_rc;
    logic [3:0]  sc_rrd, sc_bl;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          pop_cyc  = 0;
    bit          ack_en   = 1'b1;
    logic [7:0]  sb[$];

    sdr_cmd_decode dut (
        .clk0(clk0), .reset(reset), .cmd(cmd), .addr(addr), .cmdack(cmdack),
        .seq_busy(seq_busy), .cmack(cmack), .load_time(load_time),
        .load_rfcnt(load_rfcnt), .do_reada(do_reada), .do_writea(do_writea),
        .do_refresh(do_refresh), .do_precharge(do_precharge),
        .do_load_mode(do_load_mode), .ref_req(ref_req), .sc_cl(sc_cl),
        .sc_rc(sc_rc), .sc_rrd(sc_rrd), .sc_pm(sc_pm), .sc_bl(sc_bl)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Acknowledge stage model: cmdack one cycle after any accepted strobe.
    always @(posedge clk0) begin
        #1;
        cmdack = ack_en && (cmack || load_time || load_rfcnt);
    end

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk0) begin
        logic [7:0] p;
        logic [7:0] e;
        p = {cmack, load_time, load_rfcnt, do_reada, do_writea,
             do_refresh, do_precharge, do_load_mode};
        if (p !== 8'h00) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {24'd0, p}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_vs_expected", {24'd0, p}, {24'd0, e});
                pop_cyc = cyc;
            end
        end
    end

    task automatic wait_sb_empty(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk0); #1;
            if (sb.size() == 0) break;
        end
        check({name, "_issued"}, 32'(sb.size() == 0), 32'd1);
    endtask

    // Host side: hold cmd until its own strobe is seen and cmdack follows.
    task automatic wait_ack(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk0); #1;
            if (sb.size() == 0 && cmdack) break;
        end
        check({name, "_acked"}, 32'(sb.size() == 0 && cmdack), 32'd1);
        cmd = 3'd0;
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [22:0] a,
                          input logic [7:0] exp, input string name);
        @(negedge clk0);
        cmd  = c;
        addr = a;
        sb.push_back(exp);
        wait_ack(name);
    endtask

    task automatic poll_ref_req(input int budget, output int seen_cyc);
        seen_cyc = -100;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk0); #1;
            if (ref_req === 1'b1) begin
                seen_cyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int load_cyc, rise_cyc, rel_cyc;
        reset = 1'b0; cmd = 3'd0; addr = '0; seq_busy = 1'b0; cmdack = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        check("reset_pulses", {24'd0, cmack, load_time, load_rfcnt, do_reada, do_writea,
              do_refresh, do_precharge, do_load_mode}, 32'd0);
        check("reset_config", {19'd0, sc_cl, sc_rc, sc_rrd, sc_pm, sc_bl}, {19'd0, CFG_DEF});
        check("reset_ref_req", {31'd0, ref_req}, 32'd0);
        reset = 1'b1;

        // READA with idle sequencer; no reissue afterwards.
        do_cmd(3'd1, 23'd0, P_READA, "reada");
        repeat (6) @(negedge clk0);

        // LOAD_TIME with addr 0x1A5.
        do_cmd(3'd6, 23'h1A5, P_LTIME, "load_time");
        check("config_after_load", {19'd0, sc_cl, sc_rc, sc_rrd, sc_pm, sc_bl},
              {19'd0, 2'd1, 2'd1, 4'hA, 1'b1, 4'd0});

        // LOAD_RFCNT 10: ref_req 10-11 cycles later, then an auto refresh.
        do_cmd(3'd7, 23'd10, P_LRF, "load_rfcnt10");
        load_cyc = pop_cyc;
        sb.push_back(P_REFRESH);
        poll_ref_req(40, rise_cyc);
        check("ref_req_rise_10_to_11",
              32'((rise_cyc - load_cyc >= 10) && (rise_cyc - load_cyc <= 11)), 32'd1);
        wait_sb_empty("auto_refresh");
        check("ref_req_cleared", {31'd0, ref_req}, 32'd0);
        do_cmd(3'd7, 23'd2000, P_LRF, "load_rfcnt2000");

        // WRITEA held off by a busy sequencer for 5 cycles.
        @(negedge clk0);
        seq_busy = 1'b1; cmd = 3'd2; addr = '0;
        sb.push_back(P_WRITEA);
        repeat (5) @(negedge clk0);
        check("writea_held_while_busy", 32'(sb.size()), 32'd1);
        #1;
        seq_busy = 1'b0;
        rel_cyc  = cyc;
        wait_ack("writea");
        check("writea_first_idle_cycle", 32'(pop_cyc - rel_cyc), 32'd1);

        // Interval 0 behaves as 1; ref_req stays up while the sequencer is busy.
        @(negedge clk0);
        seq_busy = 1'b1;
        do_cmd(3'd7, 23'd0, P_LRF, "load_rfcnt0");
        poll_ref_req(8, rise_cyc);
        check("rfcnt0_ref_req", {31'd0, ref_req}, 32'd1);
        do_cmd(3'd7, 23'd2000, P_LRF, "load_rfcnt2000_busy");
        check("ref_req_held_while_busy", {31'd0, ref_req}, 32'd1);

        // Pending refresh and PRECHARGE together: refresh goes first.
        @(negedge clk0);
        cmd = 3'd4; addr = '0; seq_busy = 1'b0;
        sb.push_back(P_REFRESH);
        sb.push_back(P_PRECH);
        wait_ack("refresh_then_precharge");
        check("ref_req_after_refresh", {31'd0, ref_req}, 32'd0);

        // Reset while waiting for cmdack abandons the command.
        ack_en = 1'b0;
        @(negedge clk0);
        cmd = 3'd1;
        sb.push_back(P_READA);
        wait_sb_empty("reada_before_reset");
        cmd   = 3'd0;
        reset = 1'b0;
        repeat (2) @(negedge clk0);
        #1;
        reset = 1'b1;
        check("config_after_mid_reset", {19'd0, sc_cl, sc_rc, sc_rrd, sc_pm, sc_bl},
              {19'd0, CFG_DEF});
        check("ref_req_after_mid_reset", {31'd0, ref_req}, 32'd0);
        ack_en = 1'b1;
        repeat (10) @(negedge clk0);
        do_cmd(3'd1, 23'd0, P_READA, "reada_after_reset");

        repeat (20) @(negedge clk0);
        check("expectations_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
